// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, IR field positions and fetch FSM state for the multicycle CPU.
package cpu_pkg;
  localparam int DATA_W_DEF = 16;
  localparam logic [3:0] OP_ADD_REG = 4'b1000;
  localparam logic [3:0] OP_LOAD    = 4'b0001;
  localparam logic [3:0] OP_STORE   = 4'b0010;
  localparam logic [3:0] OP_BEQ     = 4'b0100;
  localparam logic [3:0] OP_BNE     = 4'b0101;
  localparam logic [3:0] OP_JMP     = 4'b0011;
  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int RA_HI = 11;
  localparam int RA_LO = 8;
  localparam int RB_HI = 7;
  localparam int RB_LO = 4;
  localparam int FUNC_HI = 3;
  localparam int FUNC_LO = 0;
  localparam int IMM_HI = 7;
  localparam int JMP_HI = 11;
  typedef enum logic {F_IDLE, F_WAIT} fetch_state_t;
endpackage

// File: rtl/sign_ext.sv
// sign_ext: replicates the top input bit to widen a field to OUT_W bits.
module sign_ext #(
  parameter int IN_W = 4,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  a,
  output logic [OUT_W-1:0] y
);
  assign y = {{(OUT_W-IN_W){a[IN_W-1]}}, a};
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC/IR stage with req/ack instruction fetch; FETCH_TIMEOUT_EN adds a WAIT watchdog.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IntMemRead,
  input  logic              IRWrite,
  input  logic              PCWrite,
  input  logic              PCWriteCond,
  input  logic              PCSrc,
  input  logic              FlagSel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              fetch_stall,
  output logic              fetch_err,
  output logic [DATA_W-1:0] pc,
  output logic [3:0]        op,
  output logic [3:0]        func,
  output logic [3:0]        ra,
  output logic [3:0]        rb,
  output logic [7:0]        imm8,
  output logic [DATA_W-1:0] jmp_off
);
  fetch_state_t state;
  logic [DATA_W-1:0] ir, addr_q, br_off, pc_next;
  logic pc_we, ir_we, tout;
  sign_ext #(.IN_W(FUNC_HI-FUNC_LO+1), .OUT_W(DATA_W)) u_br (.a(ir[FUNC_HI:FUNC_LO]), .y(br_off));
  sign_ext #(.IN_W(JMP_HI+1), .OUT_W(DATA_W)) u_jmp (.a(ir[JMP_HI:0]), .y(jmp_off));
  assign op = ir[OP_HI:OP_LO];
  assign ra = ir[RA_HI:RA_LO];
  assign rb = ir[RB_HI:RB_LO];
  assign func = ir[FUNC_HI:FUNC_LO];
  assign imm8 = ir[IMM_HI:0];
  // The address is frozen on WAIT entry so a stray PC write cannot move an outstanding read.
  always_comb begin
    imem_req = IntMemRead & ~rst;
    fetch_stall = imem_req & ~imem_ack;
    imem_addr = state == F_WAIT ? addr_q : pc;
    ir_we = IRWrite & imem_req & imem_ack;
    pc_we = (PCWrite & ~fetch_stall) | (PCWriteCond & (alu_zero ^ FlagSel));
    pc_next = PCSrc ? pc + br_off : alu_result;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= F_IDLE;
      pc <= RESET_PC;
      ir <= '0;
      addr_q <= RESET_PC;
    end else if (tout) begin
      state <= F_IDLE;
      pc <= pc + DATA_W'(1);
      ir <= '0;
    end else begin
      state <= fetch_stall ? F_WAIT : F_IDLE;
      if (state == F_IDLE) addr_q <= pc;
      if (ir_we) ir <= imem_rdata;
      if (pc_we) pc <= pc_next;
    end
  end
`ifdef FETCH_TIMEOUT_EN
  logic [3:0] wd;
  assign tout = state == F_WAIT && fetch_stall && wd == 4'(TIMEOUT-1);
  always_ff @(posedge clk) begin
    if (rst) begin
      wd <= '0;
      fetch_err <= 1'b0;
    end else begin
      fetch_err <= tout;
      wd <= (state == F_WAIT && fetch_stall && !tout) ? wd + 4'd1 : '0;
    end
  end
`else
  assign tout = 1'b0;
  assign fetch_err = 1'b0;
`endif
endmodule
